// File: rtl/accum_pkg.sv
// Shared types and parameter derivations for the chunk-serial accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_CHUNK  = 4;
  localparam int DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;

  // Number of CHUNK-bit slices in a WIDTH-bit word.
  function automatic int chunk_count(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Bits needed for the chunk index; never narrower than one bit.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/accum_unit_if.sv
// Request/result bundle of the accumulator.
interface accum_unit_if #(
  parameter int WIDTH = 16
);
  logic             Run;
  logic             Clear;
  logic             Sub;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Acc;
  logic             Carry;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, Clear, Sub, Din,
    input  Acc, Carry, Busy, Done
  );

  modport slave (
    input  Run, Clear, Sub, Din,
    output Acc, Carry, Busy, Done
  );
endinterface

// File: rtl/accum_unit_chunk_adder.sv
// CHUNK-bit combinational adder slice, time-shared across the word.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Cin,
  output logic [CHUNK-1:0] S,
  output logic             Cout
);

  // Plain ripple sum with carry-out in the extra MSB.
  always_comb begin
    {Cout, S} = {1'b0, A} + {1'b0, B} + (CHUNK+1)'(Cin);
  end

endmodule

// File: rtl/accum_unit.sv
// Chunk-serial accumulator: one add/subtract per Run press, CHUNK bits per cycle.
module accum_unit
  import accum_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int SATURATE = 0
) (
  input  logic        Clk,
  input  logic        Reset_Clear,
  accum_unit_if.slave bus
);

  localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("accum_unit: WIDTH must be within 4..64");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("accum_unit: WIDTH must be a multiple of CHUNK");
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
    $error("accum_unit: SATURATE must be 0 or 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             done_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] operand_q;
  logic             sub_q;
  logic             cin_q;
  logic [IDX_W-1:0] idx_q;

  logic             load, step, commit, clr;
  int unsigned      base;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_out;
  logic [WIDTH-1:0] result;
  logic             carry_fin;
  logic [WIDTH-1:0] acc_nxt;

  // Select the active slice; the operand is inverted for subtraction (carry-in supplies the +1).
  always_comb begin
    base    = 32'(idx_q) * 32'(CHUNK);
    a_chunk = shadow_q[base +: CHUNK];
    b_chunk = sub_q ? ~operand_q[base +: CHUNK] : operand_q[base +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .A    (a_chunk),
    .B    (b_chunk),
    .Cin  (cin_q),
    .S    (s_chunk),
    .Cout (c_out)
  );

  // Final word and flag: borrow is the inverted carry of the two's-complement subtract.
  always_comb begin
    result               = shadow_q;
    result[base +: CHUNK] = s_chunk;
    carry_fin            = sub_q ? ~c_out : c_out;
    acc_nxt              = result;
    if (SATURATE != 0 && carry_fin) begin
      acc_nxt = sub_q ? '0 : '1;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; Clear overrides everything, including Run.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    clr     = 1'b0;
    if (bus.Clear) begin
      clr     = 1'b1;
      state_d = bus.Run ? HOLD : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Run) begin
            load    = 1'b1;
            state_d = ADD;
          end
        end
        ADD: begin
          step = 1'b1;
          if (idx_q == LAST_IDX) begin
            commit  = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!bus.Run) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: capture on load, one slice per step, publish Acc/Carry only on commit.
  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      acc_q     <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      shadow_q  <= '0;
      operand_q <= '0;
      sub_q     <= 1'b0;
      cin_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      done_q <= commit;
      if (clr) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
      end else if (load) begin
        operand_q <= bus.Din;
        sub_q     <= bus.Sub;
        shadow_q  <= acc_q;
        cin_q     <= bus.Sub;
        idx_q     <= '0;
      end else if (step) begin
        shadow_q[base +: CHUNK] <= s_chunk;
        cin_q                   <= c_out;
        idx_q                   <= idx_q + 1'b1;
        if (commit) begin
          acc_q   <= acc_nxt;
          carry_q <= carry_fin;
        end
      end
    end
  end

  assign bus.Acc   = acc_q;
  assign bus.Carry = carry_q;
  assign bus.Busy  = (state_q == ADD);
  assign bus.Done  = done_q;

endmodule
